// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared encodings for the multi-cycle control sequencer: opcode constants,
// ALU operation codes, PC source select codes, FSM state encoding, error codes,
// and small opcode classification helpers used by the decode logic.
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Opcode field, instruction bits [31:24]
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;

  typedef enum logic [2:0] {
    ALU_FWD = 3'b000,
    ALU_ADD = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } aluop_e;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,  // PC+4
    PC_BRANCH = 2'b01,  // PC+4+(sext OFFSET<<2)
    PC_JUMP   = 2'b10   // jump target, same adder path as branch
  } pc_sel_e;

  typedef enum logic [2:0] {
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'b00,
    ERR_ILLEGAL    = 2'b01,
    ERR_IFETCH_TO  = 2'b10,
    ERR_DATA_TO    = 2'b11
  } err_e;

  typedef struct packed {
    aluop_e aluop;
    logic   imm_sel;
    logic   neg_sel;
  } alu_ctrl_t;

  function automatic logic is_legal(input logic [7:0] op);
    return op <= OP_SWI;
  endfunction

  function automatic logic is_load(input logic [7:0] op);
    return (op == OP_LWD) || (op == OP_LWI);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == OP_SWD) || (op == OP_SWI);
  endfunction

  // ALU setup for each opcode; sub and beq both compare via add-of-negated.
  function automatic alu_ctrl_t alu_ctrl(input logic [7:0] op);
    alu_ctrl_t c;
    c = '{aluop: ALU_FWD, imm_sel: 1'b0, neg_sel: 1'b0};
    case (op)
      OP_LOADI, OP_LWI, OP_SWI: c.imm_sel = 1'b1;
      OP_ADD:                   c.aluop   = ALU_ADD;
      OP_SUB, OP_BEQ: begin
        c.aluop   = ALU_ADD;
        c.neg_sel = 1'b1;
      end
      OP_AND:                   c.aluop   = ALU_AND;
      OP_OR:                    c.aluop   = ALU_OR;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/busy_timeout_counter.sv
// -----------------------------------------------------------------------------
// busy_timeout_counter
// Counts consecutive busy cycles while a memory wait is in progress and flags
// the cycle in which the TIMEOUT-th consecutive busy cycle occurs.
// TIMEOUT = 0 disables the timeout entirely.
//   i_clk      clock, rising edge
//   i_reset    synchronous active-high reset
//   i_clear    restart the count (asserted whenever not in a wait state)
//   i_busy     relevant busywait while in the wait state
//   o_expired  this busy cycle brings the count to TIMEOUT
// -----------------------------------------------------------------------------
module busy_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_busy,
  output logic o_expired
);

  localparam int unsigned W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_busy && (TIMEOUT > 0)) begin
      r_count <= r_count + W'(1);
    end
  end

  // r_count holds the number of earlier busy cycles, so the current busy
  // cycle is the TIMEOUT-th one when r_count equals TIMEOUT-1.
  assign o_expired = (TIMEOUT > 0) && i_busy && (r_count == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control FSM for the 8-bit single-issue processor. Steps each
// instruction through fetch, decode, execute, memory and writeback, handshakes
// with instruction/data memories via busywait, traps on illegal opcodes and on
// memory timeouts, and counts retired instructions (one per PC update).
//   i_clk, i_reset        clock and synchronous active-high reset
//   i_instruction         instruction word, opcode in [31:24]
//   i_ibusywait           instruction memory busy
//   i_dbusywait           data memory busy
//   i_zero                ALU result == 0
//   o_i_read, o_ir_load   instruction fetch request / IR latch strobe
//   o_d_read, o_d_write   data memory requests
//   o_reg_write           register file write strobe
//   o_aluop, o_imm_sel,
//   o_neg_sel             ALU operation and operand-2 controls
//   o_pc_we, o_pc_sel     PC update strobe and source select
//   o_halted, o_err_code  trap indication and cause
//   o_retired             retired instruction count, wraps at 2^CNT_W
// Outputs depend only on state, latched opcode, i_zero and the busywaits.
// -----------------------------------------------------------------------------
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instruction,
  input  logic             i_ibusywait,
  input  logic             i_dbusywait,
  input  logic             i_zero,
  output logic             o_i_read,
  output logic             o_ir_load,
  output logic             o_d_read,
  output logic             o_d_write,
  output logic             o_reg_write,
  output logic [2:0]       o_aluop,
  output logic             o_imm_sel,
  output logic             o_neg_sel,
  output logic             o_pc_we,
  output logic [1:0]       o_pc_sel,
  output logic             o_halted,
  output logic [1:0]       o_err_code,
  output logic [CNT_W-1:0] o_retired
);

  state_e           r_state;
  logic [7:0]       r_opcode;
  err_e             r_err;
  logic [CNT_W-1:0] r_retired;

  alu_ctrl_t w_alu;
  logic      w_is_load;
  logic      w_is_store;
  logic      w_tmr_clear;
  logic      w_tmr_busy;
  logic      w_expired;
  logic      w_pc_we;
  logic      w_unused_operand_bits;

  assign w_alu      = alu_ctrl(r_opcode);
  assign w_is_load  = is_load(r_opcode);
  assign w_is_store = is_store(r_opcode);

  // Only the opcode is consumed here; operands go to the datapath directly.
  assign w_unused_operand_bits = ^i_instruction[23:0];

  // The timer runs only in the two wait states; being anywhere else holds it
  // cleared, so it always starts from zero on entry to a wait state.
  assign w_tmr_clear = (r_state != S_FETCH_WAIT) && (r_state != S_MEM_WAIT);
  assign w_tmr_busy  = ((r_state == S_FETCH_WAIT) && i_ibusywait) ||
                       ((r_state == S_MEM_WAIT)   && i_dbusywait);

  busy_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_tmr_clear),
    .i_busy    (w_tmr_busy),
    .o_expired (w_expired)
  );

  // Control strobes
  // NOTE: every output is given a default before the case so that no state
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    o_i_read    = 1'b0;
    o_ir_load   = 1'b0;
    o_d_read    = 1'b0;
    o_d_write   = 1'b0;
    o_reg_write = 1'b0;
    o_aluop     = ALU_FWD;
    o_imm_sel   = 1'b0;
    o_neg_sel   = 1'b0;
    w_pc_we     = 1'b0;
    o_pc_sel    = PC_NEXT;
    case (r_state)
      S_FETCH_REQ: o_i_read = 1'b1;
      S_FETCH_WAIT: begin
        o_i_read  = 1'b1;
        o_ir_load = !i_ibusywait;
      end
      S_EXEC: begin
        o_aluop   = w_alu.aluop;
        o_imm_sel = w_alu.imm_sel;
        o_neg_sel = w_alu.neg_sel;
        if (r_opcode == OP_J) begin
          w_pc_we  = 1'b1;
          o_pc_sel = PC_JUMP;
        end else if (r_opcode == OP_BEQ) begin
          w_pc_we  = 1'b1;
          o_pc_sel = i_zero ? PC_BRANCH : PC_NEXT;
        end
      end
      S_MEM_REQ: begin
        o_aluop   = w_alu.aluop;
        o_imm_sel = w_alu.imm_sel;
        o_neg_sel = w_alu.neg_sel;
        o_d_read  = w_is_load;
        o_d_write = w_is_store;
      end
      S_MEM_WAIT: begin
        if (i_dbusywait) begin
          o_aluop   = w_alu.aluop;
          o_imm_sel = w_alu.imm_sel;
          o_neg_sel = w_alu.neg_sel;
          o_d_read  = w_is_load;
          o_d_write = w_is_store;
        end else if (w_is_store) begin
          // A store retires the moment the data memory accepts it.
          w_pc_we  = 1'b1;
          o_pc_sel = PC_NEXT;
        end
      end
      S_WB: begin
        o_aluop     = w_alu.aluop;
        o_imm_sel   = w_alu.imm_sel;
        o_neg_sel   = w_alu.neg_sel;
        o_reg_write = 1'b1;
        w_pc_we     = 1'b1;
        o_pc_sel    = PC_NEXT;
      end
      default: ;
    endcase
  end

  assign o_pc_we    = w_pc_we;
  assign o_halted   = (r_state == S_TRAP);
  assign o_err_code = r_err;
  assign o_retired  = r_retired;

  // State, latched opcode, error cause and retired count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FETCH_REQ;
      r_opcode  <= '0;
      r_err     <= ERR_NONE;
      r_retired <= '0;
    end else begin
      // No PC update ever happens in TRAP, so the count freezes there.
      if (w_pc_we) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      case (r_state)
        S_FETCH_REQ: r_state <= S_FETCH_WAIT;
        S_FETCH_WAIT: begin
          if (!i_ibusywait) begin
            r_opcode <= i_instruction[31:24];
            r_state  <= S_DECODE;
          end else if (w_expired) begin
            r_err   <= ERR_IFETCH_TO;
            r_state <= S_TRAP;
          end
        end
        S_DECODE: begin
          if (!is_legal(r_opcode)) begin
            r_err   <= ERR_ILLEGAL;
            r_state <= S_TRAP;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_load || w_is_store) begin
            r_state <= S_MEM_REQ;
          end else if ((r_opcode == OP_J) || (r_opcode == OP_BEQ)) begin
            r_state <= S_FETCH_REQ;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM_REQ: r_state <= S_MEM_WAIT;
        S_MEM_WAIT: begin
          if (!i_dbusywait) begin
            r_state <= w_is_load ? S_WB : S_FETCH_REQ;
          end else if (w_expired) begin
            r_err   <= ERR_DATA_TO;
            r_state <= S_TRAP;
          end
        end
        S_WB:    r_state <= S_FETCH_REQ;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed bench for cpu_sequencer. Two instances share all inputs:
//   u_dut : CNT_W=4,  TIMEOUT=4  (timeouts and counter wrap)
//   u_nto : CNT_W=16, TIMEOUT=0  (timeout disabled)
// The stimulus process drives one cycle at a time and pushes the hand-derived
// expected outputs for that cycle into a scoreboard queue; a monitor on the
// falling edge pops each entry and compares it with the selected instance.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        ibusy;
  logic        dbusy;
  logic        zero;

  always #5 clk = ~clk;

  // u_dut outputs
  logic       a_i_read, a_ir_load, a_d_read, a_d_write, a_reg_write;
  logic [2:0] a_aluop;
  logic       a_imm_sel, a_neg_sel, a_pc_we;
  logic [1:0] a_pc_sel;
  logic       a_halted;
  logic [1:0] a_err_code;
  logic [3:0] a_retired;

  // u_nto outputs
  logic        b_i_read, b_ir_load, b_d_read, b_d_write, b_reg_write;
  logic [2:0]  b_aluop;
  logic        b_imm_sel, b_neg_sel, b_pc_we;
  logic [1:0]  b_pc_sel;
  logic        b_halted;
  logic [1:0]  b_err_code;
  logic [15:0] b_retired;

  cpu_sequencer #(.CNT_W(4), .TIMEOUT(4)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_instruction(instr),
    .i_ibusywait(ibusy), .i_dbusywait(dbusy), .i_zero(zero),
    .o_i_read(a_i_read), .o_ir_load(a_ir_load), .o_d_read(a_d_read),
    .o_d_write(a_d_write), .o_reg_write(a_reg_write), .o_aluop(a_aluop),
    .o_imm_sel(a_imm_sel), .o_neg_sel(a_neg_sel), .o_pc_we(a_pc_we),
    .o_pc_sel(a_pc_sel), .o_halted(a_halted), .o_err_code(a_err_code),
    .o_retired(a_retired)
  );

  cpu_sequencer #(.CNT_W(16), .TIMEOUT(0)) u_nto (
    .i_clk(clk), .i_reset(reset), .i_instruction(instr),
    .i_ibusywait(ibusy), .i_dbusywait(dbusy), .i_zero(zero),
    .o_i_read(b_i_read), .o_ir_load(b_ir_load), .o_d_read(b_d_read),
    .o_d_write(b_d_write), .o_reg_write(b_reg_write), .o_aluop(b_aluop),
    .o_imm_sel(b_imm_sel), .o_neg_sel(b_neg_sel), .o_pc_we(b_pc_we),
    .o_pc_sel(b_pc_sel), .o_halted(b_halted), .o_err_code(b_err_code),
    .o_retired(b_retired)
  );

  typedef struct packed {
    logic       i_read;
    logic       ir_load;
    logic       d_read;
    logic       d_write;
    logic       reg_write;
    logic [2:0] aluop;
    logic       imm_sel;
    logic       neg_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       halted;
    logic [1:0] err;
    logic [3:0] retired;  // low four bits
  } obs_t;

  typedef struct {
    string nm;
    obs_t  e;
    bit    nto;
  } item_t;

  item_t sb_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Expected-output builder; argument order:
  // i_read, ir_load, d_read, d_write, reg_write, aluop, imm, neg,
  // pc_we, pc_sel, halted, err, retired
  function automatic obs_t o(input int ir, input int il, input int dr,
                             input int dw, input int rw, input int op,
                             input int im, input int ng, input int pw,
                             input int ps, input int h, input int er,
                             input int ret);
    obs_t r;
    r.i_read    = ir[0];
    r.ir_load   = il[0];
    r.d_read    = dr[0];
    r.d_write   = dw[0];
    r.reg_write = rw[0];
    r.aluop     = op[2:0];
    r.imm_sel   = im[0];
    r.neg_sel   = ng[0];
    r.pc_we     = pw[0];
    r.pc_sel    = ps[1:0];
    r.halted    = h[0];
    r.err       = er[1:0];
    r.retired   = ret[3:0];
    return r;
  endfunction

  function automatic obs_t obs_dut();
    return '{a_i_read, a_ir_load, a_d_read, a_d_write, a_reg_write, a_aluop,
             a_imm_sel, a_neg_sel, a_pc_we, a_pc_sel, a_halted, a_err_code,
             a_retired};
  endfunction

  function automatic obs_t obs_nto();
    return '{b_i_read, b_ir_load, b_d_read, b_d_write, b_reg_write, b_aluop,
             b_imm_sel, b_neg_sel, b_pc_we, b_pc_sel, b_halted, b_err_code,
             b_retired[3:0]};
  endfunction

  function automatic string fmt(input obs_t v);
    return $sformatf("ir=%b il=%b dr=%b dw=%b rw=%b alu=%b imm=%b neg=%b pcwe=%b pcsel=%b h=%b err=%b ret=%0d",
                     v.i_read, v.ir_load, v.d_read, v.d_write, v.reg_write, v.aluop,
                     v.imm_sel, v.neg_sel, v.pc_we, v.pc_sel, v.halted, v.err, v.retired);
  endfunction

  // Monitor: compares one scoreboard entry per cycle, mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      item_t it;
      obs_t  act;
      it  = sb_q.pop_front();
      act = it.nto ? obs_nto() : obs_dut();
      n_checks++;
      if (act === it.e) n_pass++;
      else $display("FAIL %s: got [%s] expected [%s]", it.nm, fmt(act), fmt(it.e));
    end
  end

  // Drive inputs for the current cycle, record its expectation, advance.
  task automatic cyc(input string nm, input int ib, input int db, input int z,
                     input obs_t e, input int nto = 0);
    item_t it;
    ibusy = ib[0];
    dbusy = db[0];
    zero  = z[0];
    it.nm  = nm;
    it.e   = e;
    it.nto = nto[0];
    sb_q.push_back(it);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int ib, input int db, input int z);
    ibusy = ib[0];
    dbusy = db[0];
    zero  = z[0];
    @(posedge clk); #1;
  endtask

  // Leaves the bench at the start of the first post-reset FETCH_REQ cycle.
  task automatic apply_reset();
    reset = 1'b1;
    ibusy = 1'b0;
    dbusy = 1'b0;
    zero  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // FETCH_REQ, optional fetch stalls, FETCH_WAIT with IR load, DECODE.
  // noise drives DBUSYWAIT high where it must be ignored.
  task automatic fetch(input string nm, input logic [7:0] op, input int ret,
                       input int stalls, input int noise);
    instr = {op, 24'h5A3C81};
    cyc({nm, ".freq"}, 0, noise, 0, o(1,0,0,0,0, 0,0,0, 0,0, 0,0, ret));
    for (int i = 0; i < stalls; i++)
      cyc({nm, ".fstall"}, 1, noise, 0, o(1,0,0,0,0, 0,0,0, 0,0, 0,0, ret));
    cyc({nm, ".fwait"}, 0, noise, 0, o(1,1,0,0,0, 0,0,0, 0,0, 0,0, ret));
    cyc({nm, ".dec"},   0, noise, 0, o(0,0,0,0,0, 0,0,0, 0,0, 0,0, ret));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    instr = '0;
    ibusy = 1'b0;
    dbusy = 1'b0;
    zero  = 1'b0;
    @(posedge clk); #1;
    cyc("reset.held", 0, 1, 0, o(1,0,0,0,0, 0,0,0, 0,0, 0,0, 0));
    reset = 1'b0;

    // add: IR_LOAD in cycle 2, REG_WRITE+PC_WE in cycle 5
    fetch("add", 8'h02, 0, 0, 0);
    cyc("add.exec", 0,0,0, o(0,0,0,0,0, 1,0,0, 0,0, 0,0, 0));
    cyc("add.wb",   0,0,0, o(0,0,0,0,1, 1,0,0, 1,0, 0,0, 0));

    // beq taken (with one fetch stall), then not taken
    fetch("beq_t", 8'h07, 1, 1, 0);
    cyc("beq_t.exec", 0,0,1, o(0,0,0,0,0, 1,0,1, 1,1, 0,0, 1));
    fetch("beq_n", 8'h07, 2, 0, 0);
    cyc("beq_n.exec", 0,0,0, o(0,0,0,0,0, 1,0,1, 1,0, 0,0, 2));

    // sub: add with negated operand
    fetch("sub", 8'h03, 3, 0, 0);
    cyc("sub.exec", 0,0,0, o(0,0,0,0,0, 1,0,1, 0,0, 0,0, 3));
    cyc("sub.wb",   0,0,0, o(0,0,0,0,1, 1,0,1, 1,0, 0,0, 3));

    // lwd with three busy cycles: D_READ for MEM_REQ + 3
    fetch("lwd", 8'h08, 4, 0, 0);
    cyc("lwd.exec",  0,0,0, o(0,0,0,0,0, 0,0,0, 0,0, 0,0, 4));
    cyc("lwd.mreq",  0,1,0, o(0,0,1,0,0, 0,0,0, 0,0, 0,0, 4));
    for (int i = 0; i < 3; i++)
      cyc("lwd.mbusy", 0,1,0, o(0,0,1,0,0, 0,0,0, 0,0, 0,0, 4));
    cyc("lwd.mdone", 0,0,0, o(0,0,0,0,0, 0,0,0, 0,0, 0,0, 4));
    cyc("lwd.wb",    0,0,0, o(0,0,0,0,1, 0,0,0, 1,0, 0,0, 4));

    // swi: D_WRITE, PC_WE on MEM_WAIT exit, no REG_WRITE
    fetch("swi", 8'h0B, 5, 0, 0);
    cyc("swi.exec",  0,0,0, o(0,0,0,0,0, 0,1,0, 0,0, 0,0, 5));
    cyc("swi.mreq",  0,0,0, o(0,0,0,1,0, 0,1,0, 0,0, 0,0, 5));
    cyc("swi.mdone", 0,0,0, o(0,0,0,0,0, 0,0,0, 1,0, 0,0, 5));

    // swd interrupted by reset during MEM_WAIT with DBUSYWAIT high
    fetch("swd_rst", 8'h0A, 6, 0, 0);
    cyc("swd_rst.exec",  0,0,0, o(0,0,0,0,0, 0,0,0, 0,0, 0,0, 6));
    cyc("swd_rst.mreq",  0,1,0, o(0,0,0,1,0, 0,0,0, 0,0, 0,0, 6));
    cyc("swd_rst.mbusy", 0,1,0, o(0,0,0,1,0, 0,0,0, 0,0, 0,0, 6));
    reset = 1'b1;
    cyc("swd_rst.rstcyc", 0,1,0, o(0,0,0,1,0, 0,0,0, 0,0, 0,0, 6));
    reset = 1'b0;

    // swd with DBUSYWAIT stuck: u_dut traps after 4 busy cycles, u_nto waits
    fetch("swd_to", 8'h0A, 0, 0, 1);
    cyc("swd_to.exec", 0,0,0, o(0,0,0,0,0, 0,0,0, 0,0, 0,0, 0));
    cyc("swd_to.mreq", 0,1,0, o(0,0,0,1,0, 0,0,0, 0,0, 0,0, 0));
    for (int i = 0; i < 4; i++)
      cyc("swd_to.mbusy", 0,1,0, o(0,0,0,1,0, 0,0,0, 0,0, 0,0, 0));
    cyc("swd_to.trap",  0,1,0, o(0,0,0,0,0, 0,0,0, 0,0, 1,3, 0));
    cyc("nto.no_trap",  0,1,0, o(0,0,0,1,0, 0,0,0, 0,0, 0,0, 0), 1);
    repeat (997) idle(0, 1, 0);
    cyc("nto.wait1000", 0,1,0, o(0,0,0,1,0, 0,0,0, 0,0, 0,0, 0), 1);
    cyc("swd_to.trap_hold", 0,1,0, o(0,0,0,0,0, 0,0,0, 0,0, 1,3, 0));
    cyc("nto.release",  0,0,0, o(0,0,0,0,0, 0,0,0, 1,0, 0,0, 0), 1);

    // illegal opcode 0x3C: trap after DECODE, inputs ignored for 20 cycles
    apply_reset();
    fetch("ill", 8'h3C, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      cyc("ill.trap", int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
          int'($urandom_range(1, 0)), o(0,0,0,0,0, 0,0,0, 0,0, 1,1, 0));

    // reset leaves TRAP; instruction fetch then times out after 4 busy cycles
    apply_reset();
    instr = {8'h02, 24'h000000};
    cyc("ito.freq", 0,0,0, o(1,0,0,0,0, 0,0,0, 0,0, 0,0, 0));
    for (int i = 0; i < 4; i++)
      cyc("ito.fbusy", 1,0,0, o(1,0,0,0,0, 0,0,0, 0,0, 0,0, 0));
    cyc("ito.trap", 1,0,0, o(0,0,0,0,0, 0,0,0, 0,0, 1,2, 0));

    // 16 adds on the 4-bit counter: RETIRED wraps 15 -> 0
    apply_reset();
    for (int k = 0; k < 15; k++) begin
      instr = {8'h02, 24'h010203};
      repeat (5) idle(0, 0, 0);
    end
    fetch("wrap", 8'h02, 15, 0, 0);
    cyc("wrap.exec",  0,0,0, o(0,0,0,0,0, 1,0,0, 0,0, 0,0, 15));
    cyc("wrap.wb",    0,0,0, o(0,0,0,0,1, 1,0,0, 1,0, 0,0, 15));
    cyc("wrap.after", 0,0,0, o(1,0,0,0,0, 0,0,0, 0,0, 0,0, 0));

    @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
